// File: rtl/load_store_unit.sv
// Load/store initiator for the DataMem word memory: byte-addressed requests in,
// word accesses out, with read-modify-write for byte and halfword stores.
module load_store_unit #(
   parameter int ADDR_W     = 10,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_req_valid,
   output logic              io_req_ready,
   input  logic [31:0]       io_req_addr,
   input  logic [31:0]       io_req_wdata,
   input  logic              io_req_fcn,
   input  logic [2:0]        io_req_typ,
   output logic              io_resp_valid,
   output logic [31:0]       io_resp_data,
   output logic              io_resp_err,
   output logic [ADDR_W-1:0] io_mem_addr,
   output logic [31:0]       io_mem_wr_data,
   output logic [1:0]        io_mem_func,
   output logic              io_mem_en,
   input  logic [31:0]       io_mem_rd_data
);

   localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              fcn_q;
   logic [2:0]        typ_q;
   logic              err_q;
   logic [31:0]       rd_word_q;
   logic [CNT_W-1:0]  wait_cnt;

   logic        req_b;
   logic        req_h;
   logic        req_w;
   logic        req_err;
   logic        is_b_q;
   logic        is_h_q;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic [31:0] store_word;

   // Typ codes 3, 6 and 7 fall into the word class along with 2.
   assign req_b   = (io_req_typ[1:0] == 2'b00);
   assign req_h   = (io_req_typ[1:0] == 2'b01);
   assign req_w   = !req_b && !req_h;
   assign req_err = (req_h && io_req_addr[0])
                  || (req_w && (io_req_addr[1:0] != 2'b00))
                  || (io_req_addr[31:ADDR_W+2] != '0);

   assign is_b_q = (typ_q[1:0] == 2'b00);
   assign is_h_q = (typ_q[1:0] == 2'b01);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (io_req_valid) begin
               if (req_err) begin
                  next_state = S_RESP;
               end else if (io_req_fcn && req_w) begin
                  next_state = S_WR;
               end else begin
                  next_state = S_RD;
               end
            end
         end
         S_RD:   next_state = S_WAIT;
         S_WAIT: begin
            if (wait_cnt == '0) begin
               next_state = fcn_q ? S_WR : S_RESP;
            end
         end
         S_WR:   next_state = S_RESP;
         S_RESP: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Reset gates every strobe combinationally so a WR cycle hit by reset never writes.
   always_comb begin
      io_req_ready   = !reset && (state == S_IDLE);
      io_resp_valid  = !reset && (state == S_RESP);
      io_resp_err    = io_resp_valid && err_q;
      io_mem_en      = !reset && ((state == S_RD) || (state == S_WR));
      io_mem_func    = (!reset && (state == S_WR)) ? 2'b01 : 2'b00;
      io_mem_addr    = addr_q[ADDR_W+1:2];
      io_mem_wr_data = store_word;
      io_resp_data   = (io_resp_valid && !err_q && !fcn_q) ? load_data : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         fcn_q     <= 1'b0;
         typ_q     <= '0;
         err_q     <= 1'b0;
         rd_word_q <= '0;
         wait_cnt  <= '0;
      end else begin
         if (state == S_IDLE && io_req_valid) begin
            addr_q  <= io_req_addr[ADDR_W+1:0];
            wdata_q <= io_req_wdata;
            fcn_q   <= io_req_fcn;
            typ_q   <= io_req_typ;
            err_q   <= req_err;
         end
         if (state == S_RD) begin
            wait_cnt <= CNT_LAST;
         end else if (state == S_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
         if (state == S_WAIT && wait_cnt == '0) begin
            rd_word_q <= io_mem_rd_data;
         end
      end
   end

   always_comb begin
      shifted   = rd_word_q >> {addr_q[1:0], 3'b000};
      load_data = shifted;
      if (is_b_q) begin
         load_data = {{24{shifted[7] & ~typ_q[2]}}, shifted[7:0]};
      end else if (is_h_q) begin
         load_data = {{16{shifted[15] & ~typ_q[2]}}, shifted[15:0]};
      end
   end

   // Sub-word stores splice the new lane into the word fetched during RD/WAIT.
   always_comb begin
      store_word = wdata_q;
      if (is_b_q) begin
         store_word = rd_word_q;
         store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (is_h_q) begin
         store_word = rd_word_q;
         store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3), each behind
// its own DataMem model, checked by vector table, hand sequences and random traffic.
module tb_load_store_unit;

   localparam int ADDR_W = 10;
   localparam int WORDS  = 1 << ADDR_W;
   localparam int LAT_A  = 1;
   localparam int LAT_B  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic              valid_a, ready_a, fcn_a, resp_valid_a, resp_err_a, mem_en_a;
   logic [31:0]       addr_a, wdata_a, resp_data_a, mem_wr_data_a, mem_rd_data_a;
   logic [2:0]        typ_a;
   logic [ADDR_W-1:0] mem_addr_a;
   logic [1:0]        mem_func_a;

   logic              valid_b, ready_b, fcn_b, resp_valid_b, resp_err_b, mem_en_b;
   logic [31:0]       addr_b, wdata_b, resp_data_b, mem_wr_data_b, mem_rd_data_b;
   logic [2:0]        typ_b;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [1:0]        mem_func_b;

   load_store_unit #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT_A)) dut_a (
      .clk(clk), .reset(reset),
      .io_req_valid(valid_a), .io_req_ready(ready_a), .io_req_addr(addr_a),
      .io_req_wdata(wdata_a), .io_req_fcn(fcn_a), .io_req_typ(typ_a),
      .io_resp_valid(resp_valid_a), .io_resp_data(resp_data_a), .io_resp_err(resp_err_a),
      .io_mem_addr(mem_addr_a), .io_mem_wr_data(mem_wr_data_a), .io_mem_func(mem_func_a),
      .io_mem_en(mem_en_a), .io_mem_rd_data(mem_rd_data_a)
   );

   load_store_unit #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT_B)) dut_b (
      .clk(clk), .reset(reset),
      .io_req_valid(valid_b), .io_req_ready(ready_b), .io_req_addr(addr_b),
      .io_req_wdata(wdata_b), .io_req_fcn(fcn_b), .io_req_typ(typ_b),
      .io_resp_valid(resp_valid_b), .io_resp_data(resp_data_b), .io_resp_err(resp_err_b),
      .io_mem_addr(mem_addr_b), .io_mem_wr_data(mem_wr_data_b), .io_mem_func(mem_func_b),
      .io_mem_en(mem_en_b), .io_mem_rd_data(mem_rd_data_b)
   );

   // DataMem models; reads outside a mem_en read cycle return a poison word.
   logic [31:0] mem_a [WORDS];
   logic [31:0] mem_b [WORDS];
   logic [31:0] pipe_a [LAT_A];
   logic [31:0] pipe_b [LAT_B];
   logic        pre_clr, pre_we, pre_sel;
   logic [ADDR_W-1:0] pre_idx;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_clr) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_a[i] <= 32'h0;
            mem_b[i] <= 32'h0;
         end
      end else if (pre_we) begin
         if (pre_sel) mem_b[pre_idx] <= pre_data;
         else         mem_a[pre_idx] <= pre_data;
      end else begin
         if (mem_en_a && mem_func_a == 2'b01) mem_a[mem_addr_a] <= mem_wr_data_a;
         if (mem_en_b && mem_func_b == 2'b01) mem_b[mem_addr_b] <= mem_wr_data_b;
      end
      pipe_a[0] <= (mem_en_a && mem_func_a == 2'b00) ? mem_a[mem_addr_a] : 32'hBAD0BAD0;
      pipe_b[0] <= (mem_en_b && mem_func_b == 2'b00) ? mem_b[mem_addr_b] : 32'hBAD0BAD0;
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign mem_rd_data_a = pipe_a[LAT_A-1];
   assign mem_rd_data_b = pipe_b[LAT_B-1];

   int en_cnt_a = 0, wr_cnt_a = 0, acc_cnt_a = 0;
   int en_cnt_b = 0, wr_cnt_b = 0, acc_cnt_b = 0;
   always @(posedge clk) begin
      if (mem_en_a) en_cnt_a <= en_cnt_a + 1;
      if (mem_en_a && mem_func_a == 2'b01) wr_cnt_a <= wr_cnt_a + 1;
      if (valid_a && ready_a) acc_cnt_a <= acc_cnt_a + 1;
      if (mem_en_b) en_cnt_b <= en_cnt_b + 1;
      if (mem_en_b && mem_func_b == 2'b01) wr_cnt_b <= wr_cnt_b + 1;
      if (valid_b && ready_b) acc_cnt_b <= acc_cnt_b + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Reference model: byte-level view of memory, computed from the access rules.
   logic [31:0] ref_mem [2][WORDS];

   function automatic void refAccess(input int sel, input bit fcn, input logic [2:0] typ,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output bit err, output logic [31:0] data, output int lat,
                                     output int n_en, output int n_wr);
      int size;
      bit sgn;
      int lat_rd;
      longint a;
      longint v;
      int idx;
      int off;
      logic [31:0] word;
      lat_rd = (sel != 0) ? LAT_B : LAT_A;
      case (typ)
         3'd0:    begin size = 1; sgn = 1'b1; end
         3'd4:    begin size = 1; sgn = 1'b0; end
         3'd1:    begin size = 2; sgn = 1'b1; end
         3'd5:    begin size = 2; sgn = 1'b0; end
         default: begin size = 4; sgn = 1'b0; end
      endcase
      a    = longint'(addr);
      idx  = int'(a / 4);
      off  = int'(a % 4);
      err  = ((a % size) != 0) || (a >= 4 * WORDS);
      data = 32'h0;
      if (err) begin
         lat = 1; n_en = 0; n_wr = 0;
         return;
      end
      word = ref_mem[sel][idx];
      if (!fcn) begin
         v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
         if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
         data = v[31:0];
         lat = 2 + lat_rd; n_en = 1; n_wr = 0;
      end else begin
         for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = wdata[8*b +: 8];
         ref_mem[sel][idx] = word;
         lat  = (size == 4) ? 2 : 3 + lat_rd;
         n_en = (size == 4) ? 1 : 2;
         n_wr = 1;
      end
   endfunction

   task automatic driveReq(input bit sel, input bit v, input bit fcn, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata);
      if (sel) begin
         valid_b = v; fcn_b = fcn; typ_b = typ; addr_b = addr; wdata_b = wdata;
      end else begin
         valid_a = v; fcn_a = fcn; typ_a = typ; addr_a = addr; wdata_a = wdata;
      end
   endtask

   task automatic preload(input bit sel, input int idx, input logic [31:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_sel = sel; pre_idx = ADDR_W'(idx); pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
      ref_mem[sel][idx] = data;
   endtask

   task automatic applyStimulus(input bit sel, input bit fcn, input logic [2:0] typ,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output bit got_err, output logic [31:0] got_data,
                                output int got_lat, output int got_en, output int got_wr,
                                output bit pulse_ok);
      int en0, wr0;
      @(negedge clk);
      en0 = sel ? en_cnt_b : en_cnt_a;
      wr0 = sel ? wr_cnt_b : wr_cnt_a;
      driveReq(sel, 1'b1, fcn, typ, addr, wdata);
      @(posedge clk);
      #1 driveReq(sel, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      got_lat = -1; got_err = 1'b0; got_data = 32'h0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sel ? resp_valid_b : resp_valid_a) begin
            got_lat  = k;
            got_err  = sel ? resp_err_b : resp_err_a;
            got_data = sel ? resp_data_b : resp_data_a;
            break;
         end
      end
      @(negedge clk);
      pulse_ok = sel ? (!resp_valid_b && ready_b) : (!resp_valid_a && ready_a);
      got_en = (sel ? en_cnt_b : en_cnt_a) - en0;
      got_wr = (sel ? wr_cnt_b : wr_cnt_a) - wr0;
   endtask

   task automatic runAndCompare(input bit sel, input string tag, input bit fcn,
                                input logic [2:0] typ, input logic [31:0] addr,
                                input logic [31:0] wdata);
      bit g_err, e_err, pulse;
      logic [31:0] g_data, e_data;
      int g_lat, e_lat, g_en, e_en, g_wr, e_wr;
      logic [ADDR_W-1:0] idx;
      applyStimulus(sel, fcn, typ, addr, wdata, g_err, g_data, g_lat, g_en, g_wr, pulse);
      refAccess(sel, fcn, typ, addr, wdata, e_err, e_data, e_lat, e_en, e_wr);
      checkOutput({tag, "_err"},   32'(g_err), 32'(e_err));
      checkOutput({tag, "_data"},  g_data, e_data);
      checkOutput({tag, "_lat"},   32'(g_lat), 32'(e_lat));
      checkOutput({tag, "_memen"}, 32'(g_en), 32'(e_en));
      checkOutput({tag, "_wr"},    32'(g_wr), 32'(e_wr));
      checkOutput({tag, "_pulse"}, 32'(pulse), 32'd1);
      if (addr < 32'(4 * WORDS)) begin
         idx = addr[ADDR_W+1:2];
         checkOutput({tag, "_mem"}, sel ? mem_b[idx] : mem_a[idx], ref_mem[sel][idx]);
      end
   endtask

   typedef struct {
      bit          fcn;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] data;
      int          lat;
   } vec_t;

   vec_t vecs [19];

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit g_err, pulse, seen_en, seen_resp, busy_ready;
      logic [31:0] g_data;
      int g_lat, g_en, g_wr, acc0, wr0;

      vecs[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        2};
      vecs[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 3};
      vecs[2]  = '{1'b1, 3'd2, 32'h010, 32'h11223344, 1'b0, 32'h0,        2};
      vecs[3]  = '{1'b1, 3'd0, 32'h012, 32'h000000AA, 1'b0, 32'h0,        4};
      vecs[4]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'h11AA3344, 3};
      vecs[5]  = '{1'b1, 3'd2, 32'h010, 32'h80FF0000, 1'b0, 32'h0,        2};
      vecs[6]  = '{1'b0, 3'd0, 32'h013, 32'h0,        1'b0, 32'hFFFFFF80, 3};
      vecs[7]  = '{1'b0, 3'd4, 32'h013, 32'h0,        1'b0, 32'h00000080, 3};
      vecs[8]  = '{1'b0, 3'd5, 32'h012, 32'h0,        1'b0, 32'h000080FF, 3};
      vecs[9]  = '{1'b0, 3'd1, 32'h012, 32'h0,        1'b0, 32'hFFFF80FF, 3};
      vecs[10] = '{1'b0, 3'd2, 32'h006, 32'h0,        1'b1, 32'h0,        1};
      vecs[11] = '{1'b0, 3'd1, 32'h001, 32'h0,        1'b1, 32'h0,        1};
      vecs[12] = '{1'b0, 3'd2, 32'h1000, 32'h0,       1'b1, 32'h0,        1};
      vecs[13] = '{1'b1, 3'd1, 32'h012, 32'h1234CAFE, 1'b0, 32'h0,        4};
      vecs[14] = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hCAFE0000, 3};
      vecs[15] = '{1'b1, 3'd2, 32'h013, 32'h12345678, 1'b1, 32'h0,        1};
      vecs[16] = '{1'b1, 3'd4, 32'h011, 32'h00000077, 1'b0, 32'h0,        4};
      vecs[17] = '{1'b0, 3'd3, 32'h010, 32'h0,        1'b0, 32'hCAFE7700, 3};
      vecs[18] = '{1'b0, 3'd4, 32'hFFF, 32'h0,        1'b0, 32'h000000A5, 3};

      reset = 1'b1; pre_clr = 1'b1; pre_we = 1'b0; pre_sel = 1'b0; pre_idx = '0; pre_data = '0;
      driveReq(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      driveReq(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      for (int s = 0; s < 2; s++) for (int i = 0; i < WORDS; i++) ref_mem[s][i] = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pre_clr = 1'b0;
      checkOutput("reset_ready",     32'(ready_a),      32'd0);
      checkOutput("reset_resp",      32'(resp_valid_a), 32'd0);
      checkOutput("reset_resp_data", resp_data_a,       32'h0);
      checkOutput("reset_memen",     32'(mem_en_a),     32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", 32'(ready_a), 32'd1);

      preload(1'b0, WORDS - 1, 32'hA5000000);
      preload(1'b1, 16, 32'h0BADF00D);

      for (int i = 0; i < 19; i++) begin
         applyStimulus(1'b0, vecs[i].fcn, vecs[i].typ, vecs[i].addr, vecs[i].wdata,
                       g_err, g_data, g_lat, g_en, g_wr, pulse);
         checkOutput($sformatf("vec%0d_err", i),   32'(g_err), 32'(vecs[i].err));
         checkOutput($sformatf("vec%0d_data", i),  g_data, vecs[i].data);
         checkOutput($sformatf("vec%0d_lat", i),   32'(g_lat), 32'(vecs[i].lat));
         checkOutput($sformatf("vec%0d_pulse", i), 32'(pulse), 32'd1);
         begin
            bit e_err;
            logic [31:0] e_data;
            int e_lat, e_en, e_wr;
            refAccess(0, vecs[i].fcn, vecs[i].typ, vecs[i].addr, vecs[i].wdata,
                      e_err, e_data, e_lat, e_en, e_wr);
            checkOutput($sformatf("vec%0d_memen", i), 32'(g_en), 32'(e_en));
            checkOutput($sformatf("vec%0d_wr", i),    32'(g_wr), 32'(e_wr));
         end
      end
      checkOutput("word4_final", mem_a[4], 32'hCAFE7700);

      // Reset for three cycles in the middle of a load.
      @(negedge clk);
      driveReq(1'b0, 1'b1, 1'b0, 3'd2, 32'h010, 32'h0);
      @(posedge clk);
      #1 driveReq(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      seen_en = 1'b0; seen_resp = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #1;
         seen_en   = seen_en | mem_en_a;
         seen_resp = seen_resp | resp_valid_a;
         @(negedge clk);
         if (k == 2) reset = 1'b0;
      end
      checkOutput("rstload_memen", 32'(seen_en),   32'd0);
      checkOutput("rstload_resp",  32'(seen_resp), 32'd0);
      checkOutput("rstload_ready", 32'(ready_a),   32'd1);

      // Reset landing on the write cycle of a word store.
      @(negedge clk);
      wr0 = wr_cnt_a;
      driveReq(1'b0, 1'b1, 1'b1, 3'd2, 32'h020, 32'h55555555);
      @(posedge clk);
      #1 begin
         reset = 1'b1;
         driveReq(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      end
      @(negedge clk);
      checkOutput("rstwr_memen", 32'(mem_en_a), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("rstwr_ready", 32'(ready_a), 32'd1);
      checkOutput("rstwr_resp",  32'(resp_valid_a), 32'd0);
      checkOutput("rstwr_wrcnt", 32'(wr_cnt_a - wr0), 32'd0);
      checkOutput("rstwr_mem",   mem_a[8], ref_mem[0][8]);

      // Latency-3 instance with valid held high through the whole transaction.
      @(negedge clk);
      acc0 = acc_cnt_b;
      driveReq(1'b1, 1'b1, 1'b0, 3'd2, 32'h040, 32'h0);
      @(posedge clk);
      g_lat = -1; g_data = 32'h0; busy_ready = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (resp_valid_b) begin
            g_lat = k; g_data = resp_data_b;
            driveReq(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            break;
         end
         busy_ready = busy_ready | ready_b;
      end
      @(negedge clk);
      checkOutput("lat3_lat",        32'(g_lat), 32'd5);
      checkOutput("lat3_data",       g_data, 32'h0BADF00D);
      checkOutput("lat3_busy_ready", 32'(busy_ready), 32'd0);
      checkOutput("lat3_accepts",    32'(acc_cnt_b - acc0), 32'd1);

      for (int n = 0; n < 240; n++) begin
         bit sel, fcn;
         logic [2:0] typ;
         logic [31:0] addr;
         sel  = 1'($urandom_range(0, 1));
         fcn  = 1'($urandom_range(0, 1));
         typ  = 3'($urandom_range(0, 7));
         addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 31));
         runAndCompare(sel, $sformatf("rnd%0d", n), fcn, typ, addr, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
